mem_request_arbiter: RTL and testbench

- N-channel successor to the single-core request unit.
- Collects load/store requests from NREQ requesters (icache/dcache ports of one or more cores) and grants one at a time to the memory controller.
- Grant order is round-robin. Each grant is held until memory completes it, with a one-cycle release gap after every completion.
- Returns hit/load data to the granted requester only. Sits between the cache request ports and memory_control.

---
 rtl/mem_request_arbiter_pkg.sv | 18 +
 rtl/mem_request_arbiter_if.sv | 43 ++++
 rtl/mem_request_arbiter_rr_pick.sv | 30 +++
 rtl/mem_request_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_request_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_request_arbiter_pkg.sv
// Shared types and limits for the memory request arbiter.
// Imported by the arbiter top, its interface and the round-robin picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

    localparam int MAX_NREQ = 8;

    // Next channel after p, wrapping modulo n.
    function automatic int rr_next(input int p, input int n);
        return (p + 1) % n;
    endfunction

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Request-port and memory-side bundle of the arbiter.
// slave: the arbiter; master: requesters plus memory_control.
interface mem_request_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]        req_ren;
    logic [NREQ-1:0]        req_wen;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_hit;
    logic [DATA_W-1:0]      req_rdata;
    logic                   mem_ren;
    logic                   mem_wen;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_wait;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;

    modport slave (
        input  req_ren, req_wen, req_addr, req_wdata,
        input  mem_wait, mem_rdata,
        output req_hit, req_rdata,
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        output grant_valid, grant_idx
    );

    modport master (
        output req_ren, req_wen, req_addr, req_wdata,
        output mem_wait, mem_rdata,
        input  req_hit, req_rdata,
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        input  grant_valid, grant_idx
    );

endinterface

// File: rtl/mem_request_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req
// scanning from last_ptr+1, wrapping modulo NREQ.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_ptr,
    output logic                    found,
    output logic [$clog2(NREQ)-1:0] idx
);
    localparam int IDX_W = $clog2(NREQ);

    // Walk every channel once, starting just after the last grant.
    always_comb begin
        int c;
        found = 1'b0;
        idx   = '0;
        c     = int'(last_ptr);
        for (int k = 0; k < NREQ; k++) begin
            c = rr_next(c, NREQ);
            if (!found && req[IDX_W'(c)]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter from NREQ cache request ports to memory_control.
// MEM_REQ_ARB_WPRIO_EN: pending writes are granted ahead of reads.
module mem_request_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    mem_request_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NREQ);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

    logic [NREQ-1:0]   pend;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              g_ren, g_wen;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    assign pend = bus.req_ren | bus.req_wen;

`ifdef MEM_REQ_ARB_WPRIO_EN
    logic             w_found, a_found;
    logic [IDX_W-1:0] w_idx, a_idx;

    rr_pick #(.NREQ(NREQ)) u_pick_wr (
        .req      (bus.req_wen),
        .last_ptr (last_ptr_q),
        .found    (w_found),
        .idx      (w_idx)
    );

    rr_pick #(.NREQ(NREQ)) u_pick_all (
        .req      (pend),
        .last_ptr (last_ptr_q),
        .found    (a_found),
        .idx      (a_idx)
    );

    assign pick_found = w_found | a_found;
    assign pick_idx   = w_found ? w_idx : a_idx;
`else
    rr_pick #(.NREQ(NREQ)) u_pick_all (
        .req      (pend),
        .last_ptr (last_ptr_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );
`endif

    assign g_ren   = bus.req_ren[grant_idx_q];
    assign g_wen   = bus.req_wen[grant_idx_q];
    assign g_addr  = bus.req_addr[int'(grant_idx_q)*ADDR_W +: ADDR_W];
    assign g_wdata = bus.req_wdata[int'(grant_idx_q)*DATA_W +: DATA_W];

    assign bus.grant_idx = grant_idx_q;

    // Next-state and outputs; memory strobes only ever come from BUSY.
    always_comb begin
        state_d         = state_q;
        last_ptr_d      = last_ptr_q;
        grant_idx_d     = grant_idx_q;
        bus.grant_valid = 1'b0;
        bus.mem_ren     = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.req_hit     = '0;
        bus.req_rdata   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_idx_d = pick_idx;
                    last_ptr_d  = pick_idx;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                bus.grant_valid = 1'b1;
                if (!g_ren && !g_wen) begin
                    state_d = IDLE;
                end else begin
                    bus.mem_wen   = g_wen;
                    bus.mem_ren   = g_ren & ~g_wen;
                    bus.mem_addr  = g_addr;
                    bus.mem_wdata = g_wdata;
                    if (!bus.mem_wait) begin
                        bus.req_hit   = NREQ'(1) << grant_idx_q;
                        bus.req_rdata = bus.mem_rdata;
                        state_d       = RELEASE;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            last_ptr_q  <= IDX_W'(NREQ - 1);
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            last_ptr_q  <= last_ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter.
// Build with MEM_REQ_ARB_WPRIO_EN to add the write-priority case (NREQ=4).
`timescale 1ns/1ps
module tb_mem_request_arbiter;

`ifdef MEM_REQ_ARB_WPRIO_EN
    localparam int NREQ = 4;
`else
    localparam int NREQ = 2;
`endif
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic CLK;
    logic nRST;

    int n_chk;
    int n_fail;

    int              hit_cyc[$];
    logic [NREQ-1:0] hit_vec[$];

    mem_request_arbiter_if #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) bus ();

    mem_request_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_addr(input int ch, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        bus.req_addr[ch*ADDR_W +: ADDR_W]  = a;
        bus.req_wdata[ch*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        logic [NREQ-1:0] clr;
        n_chk  = 0;
        n_fail = 0;
        nRST           = 1'b0;
        bus.req_ren    = '0;
        bus.req_wen    = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_wait   = 1'b0;
        bus.mem_rdata  = '0;

        // reset state
        cyc();
        cyc();
        check("rst_gvalid", bus.grant_valid, 0);
        check("rst_gidx", bus.grant_idx, 0);
        check("rst_mren", bus.mem_ren, 0);
        check("rst_mwen", bus.mem_wen, 0);
        check("rst_maddr", bus.mem_addr, 0);
        check("rst_hit", bus.req_hit, 0);
        check("rst_rdata", bus.req_rdata, 0);
        nRST = 1'b1;

        // single read on channel 1
        cyc();
        bus.req_ren[1] = 1'b1;
        set_addr(1, 32'h40, 32'h0);
        bus.mem_rdata = 32'hDEADBEEF;
        settle();
        check("rd_idle_mren", bus.mem_ren, 0);
        cyc();
        settle();
        check("rd_mren", bus.mem_ren, 1);
        check("rd_maddr", bus.mem_addr, 32'h40);
        check("rd_hit", bus.req_hit, 2);
        check("rd_rdata", bus.req_rdata, 32'hDEADBEEF);
        check("rd_gidx", bus.grant_idx, 1);
        cyc();
        bus.req_ren = '0;
        settle();
        check("rd_rel_mren", bus.mem_ren, 0);
        check("rd_rel_hit", bus.req_hit, 0);
        check("rd_rel_gvalid", bus.grant_valid, 0);

        // contention: channels 0 and 1 always pending
        cyc();
        bus.req_ren[0] = 1'b1;
        bus.req_ren[1] = 1'b1;
        set_addr(0, 32'h10, 32'h0);
        set_addr(1, 32'h20, 32'h0);
        for (int c = 0; c < 12; c++) begin
            settle();
            if (bus.req_hit != '0) begin
                hit_cyc.push_back(c);
                hit_vec.push_back(bus.req_hit);
            end
            cyc();
        end
        bus.req_ren = '0;
        settle();
        check("cont_nhits", hit_vec.size(), 4);
        for (int k = 0; k < hit_vec.size() && k < 4; k++) begin
            check("cont_order", hit_vec[k], (k % 2 == 0) ? 1 : 2);
            if (k > 0)
                check("cont_gap", hit_cyc[k] - hit_cyc[k-1], 3);
        end
        check("cont_first_cyc", hit_cyc.size() > 0 ? hit_cyc[0] : -1, 1);

        // write with 4 wait states on channel 0
        cyc();
        bus.req_wen[0] = 1'b1;
        set_addr(0, 32'h80, 32'h1234);
        bus.mem_wait = 1'b1;
        settle();
        check("wr_idle_mwen", bus.mem_wen, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            bus.mem_wait = (k < 5);
            settle();
            check("wr_mwen", bus.mem_wen, 1);
            check("wr_mren", bus.mem_ren, 0);
            check("wr_maddr", bus.mem_addr, 32'h80);
            check("wr_mwdata", bus.mem_wdata, 32'h1234);
            check("wr_hit", bus.req_hit, (k == 5) ? 1 : 0);
        end
        cyc();
        bus.req_wen = '0;
        settle();
        check("wr_rel_mwen", bus.mem_wen, 0);
        check("wr_rel_hit", bus.req_hit, 0);

        // abort: channel 0 drops its read while memory waits
        cyc();
        bus.req_ren[0] = 1'b1;
        bus.mem_wait = 1'b1;
        settle();
        cyc();
        bus.req_ren[1] = 1'b1;
        settle();
        check("ab_gidx", bus.grant_idx, 0);
        check("ab_mren", bus.mem_ren, 1);
        check("ab_hit_wait", bus.req_hit, 0);
        cyc();
        bus.req_ren[0] = 1'b0;
        settle();
        check("ab_nohit", bus.req_hit, 0);
        check("ab_mren_drop", bus.mem_ren, 0);
        cyc();
        settle();
        check("ab_idle", bus.grant_valid, 0);
        check("ab_idle_hit", bus.req_hit, 0);
        cyc();
        bus.mem_wait = 1'b0;
        settle();
        check("ab_next_gvalid", bus.grant_valid, 1);
        check("ab_next_gidx", bus.grant_idx, 1);
        check("ab_next_hit", bus.req_hit, 2);
        cyc();
        bus.req_ren = '0;
        settle();
        check("ab_rel_mren", bus.mem_ren, 0);

        // asynchronous reset during a waiting write on channel 0
        cyc();
        bus.req_wen[0] = 1'b1;
        set_addr(0, 32'h100, 32'h55);
        bus.mem_wait = 1'b1;
        settle();
        cyc();
        settle();
        check("rb_mwen", bus.mem_wen, 1);
        check("rb_gidx", bus.grant_idx, 0);
        #2;
        nRST = 1'b0;
        #1;
        check("rb_async_mwen", bus.mem_wen, 0);
        check("rb_async_gvalid", bus.grant_valid, 0);
        check("rb_async_maddr", bus.mem_addr, 0);
        bus.req_wen[1] = 1'b1;
        set_addr(1, 32'h200, 32'h66);
        bus.mem_wait = 1'b0;
        cyc();
        nRST = 1'b1;
        settle();
        check("rb_held_gvalid", bus.grant_valid, 0);
        cyc();
        settle();
        check("rb_prio_gidx", bus.grant_idx, 0);
        check("rb_prio_mwen", bus.mem_wen, 1);
        check("rb_prio_maddr", bus.mem_addr, 32'h100);
        check("rb_prio_hit", bus.req_hit, 1);
        cyc();
        bus.req_wen = '0;
        settle();
        cyc();

`ifdef MEM_REQ_ARB_WPRIO_EN
        // writes drain ahead of reads, last_ptr=3 after reset
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        bus.req_ren[0] = 1'b1;
        bus.req_ren[1] = 1'b1;
        bus.req_wen[3] = 1'b1;
        bus.mem_wait = 1'b0;
        hit_vec.delete();
        hit_cyc.delete();
        for (int c = 0; c < 12; c++) begin
            settle();
            clr = bus.req_hit;
            if (clr != '0) begin
                hit_cyc.push_back(c);
                hit_vec.push_back(clr);
            end
            cyc();
            bus.req_ren = bus.req_ren & ~clr;
            bus.req_wen = bus.req_wen & ~clr;
        end
        check("wp_nhits", hit_vec.size(), 3);
        if (hit_vec.size() > 0) check("wp_first", hit_vec[0], 4'b1000);
        if (hit_vec.size() > 1) check("wp_second", hit_vec[1], 4'b0001);
        if (hit_vec.size() > 2) check("wp_third", hit_vec[2], 4'b0010);
        bus.req_ren = '0;
        bus.req_wen = '0;
        cyc();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
